// File: rtl/board_pkg.sv
// board_pkg: shared constants, tile codes and clear-FSM state type for the
// board renderer. Also holds the helper that maps a sub-cell position inside
// a cell to the bit position in the tile ROM's 3x3 pattern.
package board_pkg;

   localparam int COLS       = 8;             // board columns
   localparam int ROWS       = 5;             // board rows
   localparam int TILE_W     = 9;             // 3x3 pattern width from the tile ROM
   localparam int TILE_IDX_W = 3;             // tile code width
   localparam int CELL_SUB   = 3;             // sub-cells per cell edge
   localparam int CELLS      = ROWS * COLS;   // map entries
   localparam int PTR_W      = 6;             // linear map address width

   localparam logic [TILE_IDX_W-1:0] TILE_EMPTY = 3'd0;
   localparam logic [TILE_IDX_W-1:0] TILE_CROSS = 3'd1;
   localparam logic [TILE_IDX_W-1:0] TILE_VERT  = 3'd2;
   localparam logic [TILE_IDX_W-1:0] TILE_HORZ  = 3'd3;
   localparam logic [TILE_IDX_W-1:0] TILE_NE    = 3'd4;
   localparam logic [TILE_IDX_W-1:0] TILE_NW    = 3'd5;
   localparam logic [TILE_IDX_W-1:0] TILE_SW    = 3'd6;
   localparam logic [TILE_IDX_W-1:0] TILE_SE    = 3'd7;

   typedef enum logic [0:0] {
      CLR_IDLE = 1'b0,
      CLR_RUN  = 1'b1
   } clr_state_e;

   // Pattern bit for a sub-cell: bit 8 is top-left, row-major order.
   function automatic logic [3:0] pat_sel(input logic [1:0] sub_x,
                                          input logic [1:0] sub_y);
      return 4'(TILE_W - 1) - (4'd3 * {2'b00, sub_y} + {2'b00, sub_x});
   endfunction

endpackage

// File: rtl/board_map.sv
// board_map: ROWS x COLS tile map with a single write port, a combinational
// read port addressed by (row, col), and a clear FSM that zeroes one entry
// per cycle.
// Ports:
//   clk, rst_n           clock, synchronous active-low reset (zeroes the map)
//   wr_en/wr_col/wr_row/wr_tile  write request, out-of-range ignored
//   clr                  start a full-board clear (ignored while busy)
//   busy                 clear in progress
//   rd_col/rd_row        read address, rd_tile is the stored code
module board_map
   import board_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic [2:0]            wr_col,
   input  logic [2:0]            wr_row,
   input  logic [TILE_IDX_W-1:0] wr_tile,
   input  logic                  clr,
   output logic                  busy,
   input  logic [2:0]            rd_col,
   input  logic [2:0]            rd_row,
   output logic [TILE_IDX_W-1:0] rd_tile
);

   logic [TILE_IDX_W-1:0] map_q [CELLS];
   clr_state_e            state_q, state_d;
   logic [PTR_W-1:0]      ptr_q, ptr_d;
   logic                  busy_q, busy_d;

   logic                  wr_hit_s, rd_ok_s;
   logic [PTR_W-1:0]      wr_addr_s, rd_addr_s;

   // Address decode and range qualification for both ports.
   always_comb begin
      wr_addr_s = PTR_W'(wr_row) * PTR_W'(COLS) + PTR_W'(wr_col);
      rd_addr_s = PTR_W'(rd_row) * PTR_W'(COLS) + PTR_W'(rd_col);
      wr_hit_s  = wr_en && ({1'b0, wr_col} < 4'(COLS)) && ({1'b0, wr_row} < 4'(ROWS));
      rd_ok_s   = ({1'b0, rd_col} < 4'(COLS)) && ({1'b0, rd_row} < 4'(ROWS));
   end

   // Combinational read; S2 therefore sees the value stored before this edge.
   always_comb begin
      rd_tile = TILE_EMPTY;
      if (rd_ok_s) begin
         rd_tile = map_q[rd_addr_s];
      end else begin
         rd_tile = TILE_EMPTY;
      end
   end

   // Clear FSM next state: walk ptr over every entry once, then return.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      case (state_q)
         CLR_IDLE: begin
            if (clr) begin
               state_d = CLR_RUN;
               ptr_d   = 6'd0;
            end else begin
               state_d = CLR_IDLE;
            end
         end
         CLR_RUN: begin
            if (ptr_q == PTR_W'(CELLS - 1)) begin
               state_d = CLR_IDLE;
               ptr_d   = 6'd0;
            end else begin
               ptr_d   = ptr_q + 6'd1;
            end
         end
         default: begin
            state_d = CLR_IDLE;
            ptr_d   = 6'd0;
         end
      endcase
      busy_d = (state_d == CLR_RUN);
   end

   // FSM state registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= CLR_IDLE;
         ptr_q   <= 6'd0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         busy_q  <= busy_d;
      end
   end

   // Map storage: clearing takes priority and locks out host writes.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < CELLS; i++) begin
            map_q[i] <= TILE_EMPTY;
         end
      end else if (state_q == CLR_RUN) begin
         map_q[ptr_q] <= TILE_EMPTY;
      end else if (wr_hit_s) begin
         map_q[wr_addr_s] <= wr_tile;
      end
   end

   assign busy = busy_q;

endmodule

// File: rtl/board_renderer.sv
// board_renderer: per-pixel tile renderer feeding an external 3-bit tile ROM.
// Pipeline: S1 (edge t) board hit + cell/sub-cell decode, S2 (t+1) tile_index
// from the map, ROM registers at t+2, S3 (t+3) pattern bit select. Latency from
// pixel_x/pixel_y/video_on to pixel_on/pixel_valid is a fixed 3 clocks.
// Optional macro BOARD_RENDERER_CURSOR_EN adds cur_col/cur_row; pixels of the
// cursor cell are rendered inverted.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   pixel_x, pixel_y, video_on  VGA timing inputs
//   wr_en, wr_col, wr_row, wr_tile, clr, busy   map write / clear interface
//   tile_index -> ROM, tile_bits <- ROM (valid one cycle after tile_index)
//   pixel_on, pixel_valid      rendered pixel and its in-board flag
module board_renderer
   import board_pkg::*;
#(
   parameter int SUB_SHIFT = 3,
   parameter int X0        = 64,
   parameter int Y0        = 60
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [9:0]            pixel_x,
   input  logic [9:0]            pixel_y,
   input  logic                  video_on,
   input  logic                  wr_en,
   input  logic [2:0]            wr_col,
   input  logic [2:0]            wr_row,
   input  logic [TILE_IDX_W-1:0] wr_tile,
`ifdef BOARD_RENDERER_CURSOR_EN
   input  logic [2:0]            cur_col,
   input  logic [2:0]            cur_row,
`endif
   input  logic                  clr,
   output logic                  busy,
   output logic [TILE_IDX_W-1:0] tile_index,
   input  logic [TILE_W-1:0]     tile_bits,
   output logic                  pixel_on,
   output logic                  pixel_valid
);

   localparam int         SX_W   = 10 - SUB_SHIFT;
   localparam int         CELL_PX = CELL_SUB * (1 << SUB_SHIFT);
   localparam logic [9:0] X_LO   = 10'(X0);
   localparam logic [9:0] X_HI   = 10'(X0 + CELL_PX * COLS);
   localparam logic [9:0] Y_LO   = 10'(Y0);
   localparam logic [9:0] Y_HI   = 10'(Y0 + CELL_PX * ROWS);

   // S1 decode
   logic [9:0]      dx_s, dy_s;
   logic [SX_W-1:0] sx_s, sy_s;
   logic            s1_vld_d, s1_cur_d;
   logic [2:0]      s1_col_d, s1_row_d;
   logic [1:0]      s1_subx_d, s1_suby_d;

   // pipeline registers
   logic            s1_vld_q, s1_cur_q;
   logic [2:0]      s1_col_q, s1_row_q;
   logic [1:0]      s1_subx_q, s1_suby_q;
   logic            s2_vld_q, s2_cur_q;
   logic [1:0]      s2_subx_q, s2_suby_q;
   logic            rom_vld_q, rom_cur_q;
   logic [1:0]      rom_subx_q, rom_suby_q;
   logic [TILE_IDX_W-1:0] tile_index_q, tile_index_d;
   logic            pixel_on_q, pixel_on_d;
   logic            pixel_valid_q;

   logic [TILE_IDX_W-1:0] rd_tile_s;
   logic [3:0]            sel_s;

   board_map u_map (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_en),
      .wr_col  (wr_col),
      .wr_row  (wr_row),
      .wr_tile (wr_tile),
      .clr     (clr),
      .busy    (busy),
      .rd_col  (s1_col_q),
      .rd_row  (s1_row_q),
      .rd_tile (rd_tile_s)
   );

   // S1: board hit test and cell / sub-cell split of the pixel position.
   always_comb begin
      dx_s      = pixel_x - X_LO;
      dy_s      = pixel_y - Y_LO;
      s1_vld_d  = video_on && (pixel_x >= X_LO) && (pixel_x < X_HI)
                  && (pixel_y >= Y_LO) && (pixel_y < Y_HI);
      sx_s      = SX_W'(dx_s >> SUB_SHIFT);
      sy_s      = SX_W'(dy_s >> SUB_SHIFT);
      s1_col_d  = 3'(sx_s / SX_W'(CELL_SUB));
      s1_row_d  = 3'(sy_s / SX_W'(CELL_SUB));
      s1_subx_d = 2'(sx_s % SX_W'(CELL_SUB));
      s1_suby_d = 2'(sy_s % SX_W'(CELL_SUB));
`ifdef BOARD_RENDERER_CURSOR_EN
      s1_cur_d  = s1_vld_d && (s1_col_d == cur_col) && (s1_row_d == cur_row);
`else
      s1_cur_d  = 1'b0;
`endif
   end

   // S2 tile lookup and S3 pattern bit select.
   always_comb begin
      tile_index_d = TILE_EMPTY;
      if (s1_vld_q) begin
         tile_index_d = rd_tile_s;
      end else begin
         tile_index_d = TILE_EMPTY;
      end
      sel_s      = pat_sel(rom_subx_q, rom_suby_q);
      pixel_on_d = rom_vld_q && (tile_bits[sel_s] ^ rom_cur_q);
   end

   // Pipeline registers; the rom_* stage waits out the ROM's register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_vld_q      <= 1'b0;
         s1_cur_q      <= 1'b0;
         s1_col_q      <= 3'd0;
         s1_row_q      <= 3'd0;
         s1_subx_q     <= 2'd0;
         s1_suby_q     <= 2'd0;
         s2_vld_q      <= 1'b0;
         s2_cur_q      <= 1'b0;
         s2_subx_q     <= 2'd0;
         s2_suby_q     <= 2'd0;
         rom_vld_q     <= 1'b0;
         rom_cur_q     <= 1'b0;
         rom_subx_q    <= 2'd0;
         rom_suby_q    <= 2'd0;
         tile_index_q  <= TILE_EMPTY;
         pixel_on_q    <= 1'b0;
         pixel_valid_q <= 1'b0;
      end else begin
         s1_vld_q      <= s1_vld_d;
         s1_cur_q      <= s1_cur_d;
         s1_col_q      <= s1_col_d;
         s1_row_q      <= s1_row_d;
         s1_subx_q     <= s1_subx_d;
         s1_suby_q     <= s1_suby_d;
         s2_vld_q      <= s1_vld_q;
         s2_cur_q      <= s1_cur_q;
         s2_subx_q     <= s1_subx_q;
         s2_suby_q     <= s1_suby_q;
         rom_vld_q     <= s2_vld_q;
         rom_cur_q     <= s2_cur_q;
         rom_subx_q    <= s2_subx_q;
         rom_suby_q    <= s2_suby_q;
         tile_index_q  <= tile_index_d;
         pixel_on_q    <= pixel_on_d;
         pixel_valid_q <= rom_vld_q;
      end
   end

   assign tile_index  = tile_index_q;
   assign pixel_on    = pixel_on_q;
   assign pixel_valid = pixel_valid_q;

endmodule

// File: tb/tb_board_renderer.sv
// Self-checking bench for board_renderer: a tile ROM model drives tile_bits,
// and a reference model (board array plus coordinate arithmetic) predicts
// pixel_on/pixel_valid three clocks after each driven pixel, and busy each cycle.
module tb_board_renderer;
   import board_pkg::*;

   localparam int X0 = 64;
   localparam int Y0 = 60;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [9:0] pixel_x = 10'd0, pixel_y = 10'd0;
   logic       video_on = 1'b0, wr_en = 1'b0, clr = 1'b0;
   logic [2:0] wr_col = 3'd0, wr_row = 3'd0, wr_tile = 3'd0;
   logic       busy, pixel_on, pixel_valid;
   logic [2:0] tile_index;
   logic [8:0] tile_bits = 9'd0;
`ifdef BOARD_RENDERER_CURSOR_EN
   logic [2:0] cur_c = 3'd0, cur_r = 3'd7;
`endif

   always #5 clk = ~clk;

   board_renderer dut (
      .clk(clk), .rst_n(rst_n), .pixel_x(pixel_x), .pixel_y(pixel_y),
      .video_on(video_on), .wr_en(wr_en), .wr_col(wr_col), .wr_row(wr_row),
      .wr_tile(wr_tile),
`ifdef BOARD_RENDERER_CURSOR_EN
      .cur_col(cur_c), .cur_row(cur_r),
`endif
      .clr(clr), .busy(busy), .tile_index(tile_index), .tile_bits(tile_bits),
      .pixel_on(pixel_on), .pixel_valid(pixel_valid)
   );

   function automatic logic [8:0] rom_pat(input logic [2:0] t);
      case (t)
         3'd1:    return 9'b010_111_010;
         3'd2:    return 9'b010_010_010;
         3'd3:    return 9'b000_111_000;
         3'd4:    return 9'b010_011_000;
         3'd5:    return 9'b010_110_000;
         3'd6:    return 9'b000_110_010;
         3'd7:    return 9'b000_011_010;
         default: return 9'b000_000_000;
      endcase
   endfunction

   // Tile ROM: registers the index, pattern available the following cycle.
   always @(posedge clk) tile_bits <= rom_pat(tile_index);

   typedef struct { bit chk; bit valid; bit on; } exp_t;
   exp_t     exp_q[$];
   bit [2:0] mmap [ROWS][COLS];
   int       clr_left = 0;
   int       n_tests = 0, n_fail = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
      end
   endtask

   function automatic void exp_pixel(input int x, input int y, input bit v,
                                     output bit valid, output bit on);
      int c, r, sx, sy;
      logic [8:0] pat;
      valid = v && x >= X0 && x < X0 + 24*COLS && y >= Y0 && y < Y0 + 24*ROWS;
      on = 1'b0;
      if (valid) begin
         c   = (x - X0) / 24;
         r   = (y - Y0) / 24;
         sx  = ((x - X0) % 24) / 8;
         sy  = ((y - Y0) % 24) / 8;
         pat = rom_pat(mmap[r][c]);
         on  = pat[8 - (3*sy + sx)];
`ifdef BOARD_RENDERER_CURSOR_EN
         if (c == int'(cur_c) && r == int'(cur_r)) on = !on;
`endif
      end
   endfunction

   function automatic void zero_map();
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) mmap[r][c] = 3'd0;
   endfunction

   task automatic do_reset(input int cycles);
      exp_t z;
      @(negedge clk);
      rst_n = 1'b0; video_on = 1'b0; wr_en = 1'b0; clr = 1'b0;
      repeat (cycles) @(posedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_tile_index", tile_index, 0);
      check("rst_pixel_on", pixel_on, 0);
      check("rst_pixel_valid", pixel_valid, 0);
      rst_n = 1'b1;
      zero_map();
      clr_left = 0;
      exp_q.delete();
      z.chk = 1'b1; z.valid = 1'b0; z.on = 1'b0;
      repeat (3) exp_q.push_back(z);
   endtask

   // One clock: drive inputs, update the model, check outputs after the edge.
   task automatic drive_cycle(input int x, input int y, input bit v, input bit we,
                              input int wc, input int wr, input int wt, input bit c);
      exp_t e, o;
      @(negedge clk);
      pixel_x = 10'(x); pixel_y = 10'(y); video_on = v;
      wr_en = we; wr_col = 3'(wc); wr_row = 3'(wr); wr_tile = 3'(wt); clr = c;
      e.chk = 1'b1;
      if (clr_left > 0) begin
         clr_left--;
         e.chk = 1'b0;   // partially cleared content is not predicted
      end else begin
         if (we && wc < COLS && wr < ROWS) mmap[wr][wc] = 3'(wt);
         if (c) begin
            clr_left = ROWS * COLS;
            zero_map();
            e.chk = 1'b0;
         end
      end
      exp_pixel(x, y, v, e.valid, e.on);
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      check("busy", busy, clr_left > 0);
      o = exp_q.pop_front();
      if (o.chk) begin
         check("pixel_valid", pixel_valid, o.valid);
         check("pixel_on", pixel_on, o.on);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive_cycle(0, 0, 1'b0, 1'b0, 0, 0, 0, 1'b0);
   endtask

   // One random pixel in each of the 9 sub-cells of every cell.
   task automatic subcell_scan();
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            for (int s = 0; s < 9; s++)
               drive_cycle(X0 + 24*c + 8*(s%3) + $urandom_range(0, 7),
                           Y0 + 24*r + 8*(s/3) + $urandom_range(0, 7),
                           1'b1, 1'b0, 0, 0, 0, 1'b0);
   endtask

   int busy_cnt;

   initial begin
      do_reset(2);

      // Empty board: valid only inside 192x120, never lit; one line video_off.
      for (int y = Y0 - 8; y < Y0 + 120 + 8; y++)
         for (int x = X0 - 8; x < X0 + 192 + 8; x++)
            drive_cycle(x, y, (y != Y0 + 50), 1'b0, 0, 0, 0, 1'b0);

      // Cross at (col2,row1), scan that cell with a 1-pixel margin.
      drive_cycle(0, 0, 1'b0, 1'b1, 2, 1, int'(TILE_CROSS), 1'b0);
      for (int y = Y0 + 23; y <= Y0 + 48; y++)
         for (int x = X0 + 47; x <= X0 + 72; x++)
            drive_cycle(x, y, 1'b1, 1'b0, 0, 0, 0, 1'b0);

      // Random fill, then out-of-range writes must not change anything.
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            drive_cycle(0, 0, 1'b0, 1'b1, c, r, $urandom_range(0, 7), 1'b0);
      drive_cycle(0, 0, 1'b0, 1'b1, 7, 5, 7, 1'b0);
      drive_cycle(0, 0, 1'b0, 1'b1, 3, 6, 5, 1'b0);
      drive_cycle(0, 0, 1'b0, 1'b1, 0, 7, 1, 1'b0);
      subcell_scan();

      // Same-cycle write/read: S1 pixel sees VERT, the next one HORZ.
      drive_cycle(0, 0, 1'b0, 1'b1, 0, 0, int'(TILE_VERT), 1'b0);
      idle(2);
      drive_cycle(X0 + 9, Y0 + 1, 1'b1, 1'b0, 0, 0, 0, 1'b0);
      drive_cycle(X0 + 10, Y0 + 1, 1'b1, 1'b1, 0, 0, int'(TILE_HORZ), 1'b0);
      drive_cycle(X0 + 11, Y0 + 1, 1'b1, 1'b0, 0, 0, 0, 1'b0);
      idle(3);

      // Fill with HORZ, clear; clr and wr_en during busy are ignored.
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            drive_cycle(0, 0, 1'b0, 1'b1, c, r, int'(TILE_HORZ), 1'b0);
      busy_cnt = 0;
      for (int i = 0; i < 50; i++) begin
         drive_cycle(X0 + $urandom_range(0, 191), Y0 + $urandom_range(0, 119), 1'b1,
                     (i >= 1 && i <= 40), $urandom_range(0, 7), $urandom_range(0, 4),
                     $urandom_range(1, 7), (i <= 40));
         if (busy) busy_cnt++;
      end
      check("busy_len", busy_cnt, 40);
      subcell_scan();

      // Reset in the middle of a clear.
      for (int r = 0; r < ROWS; r++)
         drive_cycle(0, 0, 1'b0, 1'b1, 4, r, int'(TILE_NE), 1'b0);
      drive_cycle(0, 0, 1'b0, 1'b0, 0, 0, 0, 1'b1);
      idle(10);
      do_reset(1);
      subcell_scan();

      // Randomised traffic: pixels around the board, writes incl. bad rows.
      for (int i = 0; i < 3000; i++) begin
`ifdef BOARD_RENDERER_CURSOR_EN
         if (i % 50 == 0) begin
            cur_c = 3'($urandom_range(0, 7));
            cur_r = 3'($urandom_range(0, 7));
         end
`endif
         drive_cycle($urandom_range(40, 280), $urandom_range(40, 200),
                     ($urandom_range(0, 9) != 0), ($urandom_range(0, 7) == 0),
                     $urandom_range(0, 7), $urandom_range(0, 7),
                     $urandom_range(0, 7), 1'b0);
      end

`ifdef BOARD_RENDERER_CURSOR_EN
      // Cursor on an empty cell: the whole cell lit, neighbours dark.
      do_reset(1);
      cur_c = 3'd3; cur_r = 3'd2;
      for (int y = Y0 + 47; y <= Y0 + 72; y++)
         for (int x = X0 + 71; x <= X0 + 96; x++)
            drive_cycle(x, y, 1'b1, 1'b0, 0, 0, 0, 1'b0);
      cur_r = 3'd7;
`endif
      idle(4);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
